// File: rtl/pwmled_fader.sv
// Multi-channel PWM LED driver with per-channel hardware fading toward a bus-written target.
// Define CLRLED_BITREV_EN to compare against the bit-reversed counter (spread on-time).
module pwmled_fader #(
    parameter int NLED = 12,
    parameter int BW   = 9,
    parameter int AW   = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_stb,
    input  logic            i_we,
    input  logic [AW-1:0]   i_addr,
    input  logic [31:0]     i_data,
    output logic            o_ack,
    output logic [31:0]     o_data,
    output logic [NLED-1:0] o_led
);

    logic [BW-1:0] cnt;
    logic [BW-1:0] cmp;
    logic          wrap;

    logic [BW-1:0] level    [NLED];
    logic [BW-1:0] target   [NLED];
    logic [7:0]    interval [NLED];
    logic [7:0]    div      [NLED];

    logic [NLED-1:0] wr_sel;
    logic [31:0]     rd_word;

    assign wrap = &cnt;

`ifdef CLRLED_BITREV_EN
    for (genvar i = 0; i < BW; i++) begin : g_bitrev
        assign cmp[i] = cnt[BW-1-i];
    end
`else
    assign cmp = cnt;
`endif

    // Address decode: out-of-range channels select nothing and read back zero.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        wr_sel  = '0;
        rd_word = '0;
        for (int k = 0; k < NLED; k++) begin
            if (i_addr == AW'(k)) begin
                wr_sel[k] = i_stb & i_we;
                rd_word   = {(level[k] != target[k]), 7'h0, interval[k], 16'(level[k])};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt    <= '0;
            o_led  <= '0;
            o_ack  <= 1'b0;
            o_data <= '0;
            // NOTE: the per-channel arrays are plain flops, not RAM, so they are reset too.
            for (int k = 0; k < NLED; k++) begin
                level[k]    <= '0;
                target[k]   <= '0;
                interval[k] <= '0;
                div[k]      <= '0;
            end
        end else begin
            // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
            cnt    <= cnt + BW'(1);
            o_ack  <= i_stb;
            o_data <= (i_stb && !i_we) ? rd_word : '0;
            for (int k = 0; k < NLED; k++) begin
                o_led[k] <= (cmp < level[k]);
                if (wr_sel[k]) begin
                    // A write always wins over a step due in the same cycle.
                    target[k]   <= i_data[BW-1:0];
                    interval[k] <= i_data[23:16];
                    div[k]      <= i_data[23:16];
                end else if (level[k] != target[k]) begin
                    if (interval[k] == 8'd0) begin
                        level[k] <= target[k];
                    end else if (wrap) begin
                        if (div[k] <= 8'd1) begin
                            level[k] <= (level[k] < target[k]) ? level[k] + BW'(1)
                                                               : level[k] - BW'(1);
                            div[k]   <= interval[k];
                        end else begin
                            div[k] <= div[k] - 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwmled_fader.sv
// Scoreboarded bench for pwmled_fader: a segment-based fade model predicts reads and every o_led sample.
module tb_pwmled_fader;

    localparam int NLED = 12;
    localparam int BW   = 9;
    localparam int AW   = 4;
    localparam int PER  = 1 << BW;

    logic            i_clk = 1'b0;
    logic            i_reset_n = 1'b0;
    logic            i_stb = 1'b0;
    logic            i_we = 1'b0;
    logic [AW-1:0]   i_addr = '0;
    logic [31:0]     i_data = '0;
    logic            o_ack;
    logic [31:0]     o_data;
    logic [NLED-1:0] o_led;

    pwmled_fader #(.NLED(NLED), .BW(BW), .AW(AW)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_stb     (i_stb),
        .i_we      (i_we),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .o_ack     (o_ack),
        .o_data    (o_data),
        .o_led     (o_led)
    );

    always #5 i_clk = ~i_clk;

    // Index of the next rising edge since reset release (edge 0 sees counter value 0).
    int cyc;
    always @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) cyc <= 0;
        else            cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fade model: each channel is a segment starting at its last write edge.
    int seg_w [NLED];
    int seg_l0[NLED];
    int seg_t [NLED];
    int seg_i [NLED];

    function automatic void model_reset();
        for (int k = 0; k < NLED; k++) begin
            seg_w[k] = -10; seg_l0[k] = 0; seg_t[k] = 0; seg_i[k] = 0;
        end
    endfunction

    // Level visible to logic sampling at edge r.
    function automatic int level_at(input int k, input int r);
        int n, steps, d;
        if (seg_i[k] == 0)
            return (r > seg_w[k] + 1) ? seg_t[k] : seg_l0[k];
        n = r / PER - (seg_w[k] + 1) / PER;   // wrap edges strictly after the write, before r
        if (n < 0) n = 0;
        steps = n / seg_i[k];
        d = (seg_t[k] > seg_l0[k]) ? seg_t[k] - seg_l0[k] : seg_l0[k] - seg_t[k];
        if (steps > d) steps = d;
        return (seg_t[k] > seg_l0[k]) ? seg_l0[k] + steps : seg_l0[k] - steps;
    endfunction

    function automatic int cmpf(input int c);
`ifdef CLRLED_BITREV_EN
        int r = 0;
        for (int i = 0; i < BW; i++) r |= ((c >> i) & 1) << (BW - 1 - i);
        return r;
`else
        return c;
`endif
    endfunction

    typedef struct {
        int          ack_at;
        logic [31:0] data;
        logic        fixed;
        logic [31:0] fixed_data;
    } exp_t;
    exp_t sb[$];

    task automatic bus(input logic we, input int addr, input logic [31:0] data,
                       input logic fixed, input logic [31:0] fixed_data);
        exp_t ex;
        int   lv;
        @(negedge i_clk);
        i_stb = 1'b1; i_we = we; i_addr = AW'(addr); i_data = data;
        ex.ack_at = cyc; ex.data = '0; ex.fixed = fixed; ex.fixed_data = fixed_data;
        if (addr < NLED) begin
            lv = level_at(addr, cyc);
            if (we) begin
                seg_l0[addr] = lv;
                seg_w[addr]  = cyc;
                seg_t[addr]  = int'(data[BW-1:0]);
                seg_i[addr]  = int'(data[23:16]);
            end else begin
                ex.data = {(lv != seg_t[addr]), 7'h0, 8'(seg_i[addr]), 16'(lv)};
            end
        end
        sb.push_back(ex);
        @(negedge i_clk);
        i_stb = 1'b0; i_we = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        bus(1'b1, addr, data, 1'b0, '0);
    endtask

    task automatic rd(input int addr);
        bus(1'b0, addr, '0, 1'b0, '0);
    endtask

    task automatic rd_exp(input int addr, input logic [31:0] value);
        bus(1'b0, addr, '0, 1'b1, value);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic duty(input string name, input int k, input int exp);
        int c = 0;
        repeat (PER) begin
            @(posedge i_clk); #2;
            c += int'(o_led[k]);
        end
        check(name, c, exp);
    endtask

    // Monitor: every cycle compares o_led against the model and pops acks off the scoreboard.
    initial begin
        int          e;
        logic        exp_ack;
        logic [NLED-1:0] exp_led;
        exp_t        ex;
        forever begin
            @(posedge i_clk); #1;
            if (!i_reset_n) begin
                check("led_in_reset", o_led, '0);
                check("ack_in_reset", o_ack, '0);
            end else begin
                e = cyc - 1;
                for (int k = 0; k < NLED; k++)
                    exp_led[k] = (cmpf(e % PER) < level_at(k, e));
                check("led", o_led, exp_led);
                exp_ack = (sb.size() > 0) && (sb[0].ack_at == e);
                check("ack", o_ack, exp_ack);
                if (exp_ack) begin
                    ex = sb.pop_front();
                    check("rdata", o_data, ex.data);
                    if (ex.fixed) check("rdata_directed", o_data, ex.fixed_data);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        seen;
        model_reset();
        idle(3);
        i_reset_n = 1'b1;
        idle(4);

        rd_exp(0, 32'h0000_0000);

        // Interval 0: level jumps to the target; 256/512 duty.
        wr(0, 32'h0000_0100);
        idle(3);
        rd_exp(0, 32'h0000_0100);
        duty("duty_ch0_256", 0, 256);
        duty("duty_ch3_level0", 3, 0);

        // Full-scale level: no 100% on.
        wr(2, 32'hFF00_01FF);
        idle(3);
        duty("duty_ch2_511", 2, 511);

        // Ramp 0 -> 4 with interval 2.
        wr(1, 32'h0002_0004);
        rd(1);
        idle(9 * PER);
        rd_exp(1, 32'h0002_0004);

        // Ramp up to 2, then retarget down to 0.
        wr(4, 32'h0002_0004);
        idle(4 * PER + 20);
        rd_exp(4, 32'h8002_0002);
        wr(4, 32'h0002_0000);
        idle(2 * PER);
        rd(4);
        idle(3 * PER);
        rd_exp(4, 32'h0002_0000);

        // Out-of-range channel: write ignored, read returns 0.
        wr(13, 32'h0003_01AB);
        idle(2);
        rd_exp(13, 32'h0000_0000);
        rd_exp(0, 32'h0000_0100);

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            d = $urandom;
            d[23:16] = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 15), d);
            else                           rd($urandom_range(0, 15));
            idle($urandom_range(0, 300));
        end

        // Async reset mid-run while channel 0 is lit.
        wr(0, 32'h0000_0100);
        idle(3);
        seen = 1'b0;
        for (int i = 0; i < 2 * PER && !seen; i++) begin
            @(posedge i_clk); #2;
            seen = o_led[0];
        end
        check("led0_seen_high", seen, 1'b1);
        i_reset_n = 1'b0;
        #1;
        check("reset_led", o_led, '0);
        check("reset_ack", o_ack, '0);
        check("reset_data", o_data, '0);
        model_reset();
        sb.delete();
        idle(3);
        i_reset_n = 1'b1;
        idle(2);
        rd_exp(0, 32'h0000_0000);
        idle(2 * PER);

        idle(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
